// File: rtl/spi_regfile_peripheral_if.sv
// spi_regfile_peripheral_if: SPI pins plus register-bank outputs between pads, target and consumers
interface spi_regfile_peripheral_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
);
    logic                       nCS;
    logic                       SCLK;
    logic                       COPI;
    logic                       CIPO;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       frame_err;
    modport master (output nCS, SCLK, COPI, input CIPO, cipo_oe, regs_flat, wr_strobe, frame_err);
    modport slave  (input nCS, SCLK, COPI, output CIPO, cipo_oe, regs_flat, wr_strobe, frame_err);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: oversampled SPI target with a read/write configuration register bank
module spi_regfile_peripheral #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_regfile_peripheral_if.slave spi
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(FRAME_LEN + 2);
    localparam logic [CW-1:0] FULL     = CW'(FRAME_LEN);
    localparam logic [CW-1:0] SAT      = CW'(FRAME_LEN + 1);
    localparam logic [CW-1:0] ADDR_END = CW'(1 + ADDR_W);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, copi_sync_q, vld_q;
    logic                   ncs_prev_q, sclk_prev_q, arm_q;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]      tx_shift_q, tx_shift_d, rd_data;
    logic                   data_smp_q, data_smp_d, cipo_q, frame_err_q;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_hit, wr_strobe_d, wr_strobe_q;
    logic                   ncs, sclk, copi, ncs_rise, sclk_rise, sclk_fall, lead, trail, smp_edge, lnch_edge;
    logic [ADDR_W-1:0]      ld_addr, wr_addr;

    assign ncs       = ncs_sync_q[SYNC_STAGES-1];
    assign sclk      = sclk_sync_q[SYNC_STAGES-1];
    assign copi      = copi_sync_q[SYNC_STAGES-1];
    assign ncs_rise  = ncs & ~ncs_prev_q;
    assign sclk_rise = sclk & ~sclk_prev_q;
    assign sclk_fall = ~sclk & sclk_prev_q;
    assign lead      = CPOL ? sclk_fall : sclk_rise;
    assign trail     = CPOL ? sclk_rise : sclk_fall;
    assign smp_edge  = CPHA ? trail : lead;
    assign lnch_edge = CPHA ? lead : trail;
    assign ld_addr   = rx_shift_q[ADDR_W-1:0];
    assign wr_addr   = rx_shift_q[DATA_W +: ADDR_W];

    assign spi.CIPO      = cipo_q;
    assign spi.cipo_oe   = ~ncs;
    assign spi.wr_strobe = wr_strobe_q;
    assign spi.frame_err = frame_err_q;
    for (genvar g = 0; g < NUM_REGS; g++) begin : flat
        assign spi.regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    // Synchronise the pins; arm only after nCS has been seen high so a frame caught mid-flight by reset is skipped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            copi_sync_q <= '0;
            vld_q       <= '0;
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= CPOL;
            arm_q       <= 1'b0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.nCS};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.COPI};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            ncs_prev_q  <= ncs;
            sclk_prev_q <= sclk;
            arm_q       <= arm_q | (vld_q[SYNC_STAGES-1] & ncs);
        end
    end

    // Read mux for the addressed register and write decode for the completed frame
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = wr_addr == ADDR_W'(i);
            if (ld_addr == ADDR_W'(i)) rd_data = regs_q[i];
        end
        wr_strobe_d = (state_q == DONE && bit_cnt_q == FULL && rx_shift_q[FRAME_LEN-1]) ? wr_hit : '0;
    end

    // Frame FSM: shift in on sample edges, load read data after the address, shift out on launch edges
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        data_smp_d = data_smp_q;
        case (state_q)
            IDLE: begin
                data_smp_d = 1'b0;
                if (arm_q && !ncs) begin
                    state_d   = ADDR;
                    bit_cnt_d = '0;
                end
            end
            ADDR, DATA: begin
                if (ncs_rise) state_d = DONE;
                else begin
                    if (smp_edge) begin
                        rx_shift_d = {rx_shift_q[FRAME_LEN-2:0], copi};
                        bit_cnt_d  = (bit_cnt_q == SAT) ? bit_cnt_q : bit_cnt_q + 1'b1;
                        data_smp_d = data_smp_q | (state_q == DATA);
                    end
                    if (state_q == ADDR && bit_cnt_q == ADDR_END) begin
                        state_d    = DATA;
                        tx_shift_d = rd_data;
                    end
                    if (state_q == DATA && lnch_edge && data_smp_q) tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame state registers and registered CIPO driven from the next-state shifter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            data_smp_q <= 1'b0;
            cipo_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            data_smp_q <= data_smp_d;
            cipo_q     <= (state_d == DATA) ? tx_shift_d[DATA_W-1] : 1'b0;
        end
    end

    // Commit a complete write, or flag a truncated/overlong frame, during the DONE cycle only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) if (wr_strobe_d[i]) regs_q[i] <= rx_shift_q[DATA_W-1:0];
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= state_q == DONE && bit_cnt_q != FULL && bit_cnt_q != '0;
        end
    end
endmodule
